// File: rtl/mips_pkg.sv
// Shared encodings for the scoreboard: bypass selects and the default result latency.
// Pure declarations; no timing or flow control of its own.
package mips_pkg;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int LAT_MAX_DEF = 4;

    // MEM result beats the WB bus: it is the younger value for the same register.
    function automatic logic [1:0] fwd_sel(input logic at_mem, input logic at_wb);
        if (at_mem)     return FWD_MEM;
        else if (at_wb) return FWD_WB;
        else            return FWD_RF;
    endfunction
endpackage

// File: rtl/mips_scoreboard_if.sv
// ID-stage request and hazard response bundle between decode and the scoreboard.
// Combinational response; stall is the only backpressure toward the front end.
interface mips_scoreboard_if #(
    parameter int RW = 5,
    parameter int LW = 3
);
    logic          id_valid;
    logic          id_flush;
    logic [RW-1:0] id_ra;
    logic [RW-1:0] id_rb;
    logic          id_ra_use;
    logic          id_rb_use;
    logic [RW-1:0] id_rw;
    logic          id_we;
    logic [LW-1:0] id_lat;
    logic          stall;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          busy_any;
    logic [15:0]   stall_cycles;

    modport master (
        output id_valid, id_flush, id_ra, id_rb, id_ra_use, id_rb_use, id_rw, id_we, id_lat,
        input  stall, fwd_a, fwd_b, busy_any, stall_cycles
    );

    modport slave (
        input  id_valid, id_flush, id_ra, id_rb, id_ra_use, id_rb_use, id_rw, id_we, id_lat,
        output stall, fwd_a, fwd_b, busy_any, stall_cycles
    );
endinterface

// File: rtl/mips_scb_entry.sv
// One register's pending-write countdown plus a one-cycle write-back pulse (MIPS_SCB_FWD_EN).
// Load takes effect next edge and overrides the decrement; no backpressure.
module mips_scb_entry #(
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [LW-1:0] lat,
    output logic [LW-1:0] cnt
`ifdef MIPS_SCB_FWD_EN
    ,
    output logic          wbf
`endif
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= lat;
        end else if (cnt != '0) begin
            cnt <= cnt - LW'(1);
        end
    end

`ifdef MIPS_SCB_FWD_EN
    // The old write still lands on the bus even when a new write reloads cnt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wbf <= 1'b0;
        else      wbf <= (cnt == LW'(1));
    end
`endif
endmodule

// File: rtl/mips_scoreboard.sv
// Register scoreboard: RAW/WAW stall detection and bypass selects; MIPS_SCB_FWD_EN enables forwarding.
// Stall and selects are combinational from ID inputs; scoreboard state updates on the next edge.
module mips_scoreboard
    import mips_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int LAT_MAX = LAT_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    mips_scoreboard_if.slave sb
);
    localparam int RW = $clog2(NREG);
    localparam int LW = $clog2(LAT_MAX + 1);
    localparam logic [LW-1:0] LAT_TOP = LW'(LAT_MAX);
`ifdef MIPS_SCB_FWD_EN
    localparam logic [LW-1:0] THR = LW'(1);
`else
    localparam logic [LW-1:0] THR = LW'(0);
`endif

    logic [NREG-1:0][LW-1:0] cnt;
    logic [NREG-1:1]         load;
    logic [NREG-1:0]         pend;
    logic [LW-1:0]           lat_c;
    logic                    haz_a, haz_b, waw, stall_i, issue;
    logic [15:0]             stall_cnt;

    always_comb begin
        if (sb.id_lat == '0)         lat_c = LW'(1);
        else if (sb.id_lat > LAT_TOP) lat_c = LAT_TOP;
        else                          lat_c = sb.id_lat;
    end

    assign haz_a   = sb.id_ra_use & (cnt[sb.id_ra] > THR);
    assign haz_b   = sb.id_rb_use & (cnt[sb.id_rb] > THR);
    assign waw     = sb.id_we & (sb.id_rw != '0) & (cnt[sb.id_rw] > lat_c);
    assign stall_i = rst & sb.id_valid & ~sb.id_flush & (haz_a | haz_b | waw);
    assign issue   = sb.id_valid & ~sb.id_flush & ~stall_i;

    always_comb begin
        load = '0;
        for (int r = 1; r < NREG; r++) begin
            load[r] = issue & sb.id_we & (sb.id_rw == RW'(r));
        end
    end

    // r0 is hardwired: never pending, never forwarded.
    assign cnt[0] = '0;

`ifdef MIPS_SCB_FWD_EN
    logic [NREG-1:0] wbf;
    assign wbf[0] = 1'b0;
`endif

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        mips_scb_entry #(.LW(LW)) u_entry (
            .clk  (clk),
            .rst  (rst),
            .load (load[r]),
            .lat  (lat_c),
            .cnt  (cnt[r])
`ifdef MIPS_SCB_FWD_EN
            ,
            .wbf  (wbf[r])
`endif
        );
    end

    always_comb begin
        pend = '0;
        for (int r = 0; r < NREG; r++) pend[r] = (cnt[r] != '0);
    end

    assign sb.stall    = stall_i;
    assign sb.busy_any = rst & (|pend);

`ifdef MIPS_SCB_FWD_EN
    assign sb.fwd_a = rst ? fwd_sel(cnt[sb.id_ra] == LW'(1), wbf[sb.id_ra]) : FWD_RF;
    assign sb.fwd_b = rst ? fwd_sel(cnt[sb.id_rb] == LW'(1), wbf[sb.id_rb]) : FWD_RF;
`else
    assign sb.fwd_a = FWD_RF;
    assign sb.fwd_b = FWD_RF;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                   stall_cnt <= '0;
        else if (stall_i && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end

    assign sb.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_mips_scoreboard.sv
// Scoreboard bench: stimulus pushes expected responses from a time-based reference model;
// a negedge monitor pops and compares. Honours MIPS_SCB_FWD_EN like the design.
module tb_mips_scoreboard;
    localparam int NREG = 32;
    localparam int LMAX = 4;
`ifdef MIPS_SCB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic        stall;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        busy;
        logic [15:0] sc;
        longint      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_scoreboard_if #(.RW(5), .LW(3)) sb ();

    mips_scoreboard #(.NREG(NREG), .LAT_MAX(LMAX)) dut (
        .clk (clk),
        .rst (rst_n),
        .sb  (sb)
    );

    exp_t   q[$];
    int     total = 0;
    int     bad = 0;
    bit     done = 1'b0;

    // Model: absolute cycle at which each register's result is architecturally written,
    // plus an extra write-back instant for a write overtaken by a reissue in its last cycle.
    longint now = 1;
    longint done_at[NREG];
    longint extra_at[NREG];
    int     sc_model = 0;

    function automatic longint rem(input int r);
        if (r == 0) return 0;
        return (done_at[r] > now) ? done_at[r] - now : 0;
    endfunction

    function automatic logic [1:0] exp_fwd(input int r);
        if (!FWD || r == 0)                          return 2'b00;
        if (rem(r) == 1)                             return 2'b10;
        if (done_at[r] == now || extra_at[r] == now) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            done_at[r]  = 0;
            extra_at[r] = 0;
        end
        sc_model = 0;
    endtask

    task automatic cyc(input bit v, input bit f, input int ra, input bit au,
                       input int rb, input bit bu, input int rw, input bit we, input int lat);
        exp_t   e;
        int     lc;
        bit     busy;
        longint thr;
        sb.id_valid  = v;
        sb.id_flush  = f;
        sb.id_ra     = 5'(ra);
        sb.id_rb     = 5'(rb);
        sb.id_ra_use = au;
        sb.id_rb_use = bu;
        sb.id_rw     = 5'(rw);
        sb.id_we     = we;
        sb.id_lat    = 3'(lat);
        lc  = (lat == 0) ? 1 : ((lat > LMAX) ? LMAX : lat);
        thr = FWD ? 1 : 0;
        busy = 1'b0;
        for (int r = 0; r < NREG; r++) if (rem(r) > 0) busy = 1'b1;
        e.stall = v && !f && ((au && rem(ra) > thr) || (bu && rem(rb) > thr) ||
                              (we && rw != 0 && rem(rw) > lc));
        e.fa   = exp_fwd(ra);
        e.fb   = exp_fwd(rb);
        e.busy = busy;
        e.sc   = 16'(sc_model);
        e.tag  = now;
        q.push_back(e);
        if (v && !f && !e.stall && we && rw != 0) begin
            if (done_at[rw] == now + 1) extra_at[rw] = now + 1;
            done_at[rw] = now + 1 + lc;
        end
        if (e.stall && sc_model < 65535) sc_model++;
        @(posedge clk);
        #1;
        now++;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rst_pulse();
        exp_t e;
        rst_n = 1'b0;
        model_clear();
        e.stall = 1'b0; e.fa = 2'b00; e.fb = 2'b00; e.busy = 1'b0; e.sc = 16'd0; e.tag = now;
        q.push_back(e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        now++;
    endtask

    task automatic chk(input string nm, input longint tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall", e.tag, 16'(sb.stall), 16'(e.stall));
            chk("fwd_a", e.tag, 16'(sb.fwd_a), 16'(e.fa));
            chk("fwd_b", e.tag, 16'(sb.fwd_b), 16'(e.fb));
            chk("busy_any", e.tag, 16'(sb.busy_any), 16'(e.busy));
            chk("stall_cycles", e.tag, sb.stall_cycles, e.sc);
        end
    end

    initial begin
        sb.id_valid = 0; sb.id_flush = 0; sb.id_ra = 0; sb.id_rb = 0;
        sb.id_ra_use = 0; sb.id_rb_use = 0; sb.id_rw = 0; sb.id_we = 0; sb.id_lat = 0;
        model_clear();
        @(posedge clk);
        #1;
        rst_pulse();
        idle();

        // single-cycle producer followed by back-to-back consumers
        cyc(1, 0, 0, 0, 0, 0, 5, 1, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 5, 1, 0, 0, 0, 0, 0);
        // three-cycle producer, dependent on the b port
        cyc(1, 0, 0, 0, 0, 0, 8, 1, 3);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 8, 1, 0, 0, 0);
        // WAW: long write then short write to the same register
        cyc(1, 0, 0, 0, 0, 0, 3, 1, 4);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 3, 1, 1);
        // latency clamp boundaries: 0 -> 1, 7 -> LAT_MAX
        cyc(1, 0, 0, 0, 0, 0, 10, 1, 0);
        cyc(1, 0, 10, 1, 0, 0, 11, 1, 7);
        for (int i = 0; i < 5; i++) cyc(1, 0, 11, 1, 10, 1, 0, 0, 0);
        // reissue in the producer's final cycle: both write-backs visible
        cyc(1, 0, 0, 0, 0, 0, 12, 1, 2);
        idle();
        cyc(1, 0, 0, 0, 0, 0, 12, 1, 2);
        for (int i = 0; i < 4; i++) cyc(1, 0, 12, 1, 12, 1, 0, 0, 0);
        // flushed hazard and writes to r0
        cyc(1, 0, 0, 0, 0, 0, 9, 1, 4);
        cyc(1, 1, 9, 1, 9, 1, 9, 1, 1);
        cyc(1, 1, 0, 0, 0, 0, 6, 1, 4);
        for (int i = 0; i < 4; i++) idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 4);
        cyc(1, 0, 0, 1, 0, 1, 0, 1, 4);
        idle();
        // reset with r7 pending, hazard on the inputs
        cyc(1, 0, 0, 0, 0, 0, 7, 1, 3);
        sb.id_valid = 1; sb.id_ra = 7; sb.id_ra_use = 1;
        rst_pulse();
        cyc(1, 0, 7, 1, 7, 1, 0, 0, 0);
        idle();

        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
                $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7));
            if (i == 700) rst_pulse();
        end
        idle();

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
